// File: rtl/seg_scan_ctrl_if.sv
// Host/display bundle for seg_scan_ctrl.
//   master: host side; drives en, wr_en, wr_addr, wr_data, commit and blank_mask.
//           It observes num_o, dig_n_o, frame_o and commit_pend_o.
//   slave : scan controller side (the mirror image of master).
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              en;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [3:0]        wr_data;
  logic              commit;
  logic [DIGITS-1:0] blank_mask;
  logic [3:0]        num_o;
  logic [DIGITS-1:0] dig_n_o;
  logic              frame_o;
  logic              commit_pend_o;

  modport master (
    output en, wr_en, wr_addr, wr_data, commit, blank_mask,
    input  num_o, dig_n_o, frame_o, commit_pend_o
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, commit, blank_mask,
    output num_o, dig_n_o, frame_o, commit_pend_o
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
// Digit codes are double-buffered:
//   - host writes land in a shadow file;
//   - the shadow file is copied into the active file at frame boundaries, or at once
//     while the display is off.
// Each digit slot is DEAD_CYC dark cycles followed by ON_CYC cycles with that digit's
// enable low. Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : host inputs and registered display outputs (see seg_scan_ctrl_if)
module seg_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned ON_CYC   = 50000,
  parameter int unsigned DEAD_CYC = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned AW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntMax = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  // Code 10 is unmapped in the shared decoder, so all segments stay off.
  localparam logic [3:0]    NumDark  = 4'd10;
  localparam logic [AW-1:0] IdxLast  = AW'(DIGITS - 1);
  localparam logic [CW-1:0] OnLast   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DeadLast = CW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {StOff, StGap, StOn} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        shadow_q [DIGITS];
  logic [3:0]        shadow_d [DIGITS];
  logic [3:0]        active_q [DIGITS];
  logic [3:0]        active_d [DIGITS];
  logic              blank_q, blank_d;
  logic [3:0]        num_q, num_d;
  logic [DIGITS-1:0] dig_n_q, dig_n_d;
  logic              frame_q, frame_d;
  logic              pend_q, pend_d;

  logic              boundary, copy, enter_gap, gap_blank;
  logic [AW-1:0]     gap_idx, idx_wrap;
  logic [3:0]        gap_num;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    num_d     = num_q;
    dig_n_d   = '1;
    frame_d   = 1'b0;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    enter_gap = 1'b0;
    gap_idx   = '0;
    gap_blank = 1'b0;
    gap_num   = NumDark;

    idx_wrap = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    boundary = bus.en && (state_q == StOn) && (cnt_q == OnLast) && (idx_q == IdxLast);

    // The copy takes the pre-edge shadow, so a same-edge write is not part of it.
    copy = (boundary && (pend_q || bus.commit)) || ((state_q == StOff) && bus.commit);
    if (copy) begin
      active_d = shadow_q;
    end
    if (boundary || ((state_q == StOff) && bus.commit)) begin
      pend_d = 1'b0;
    end else if (bus.commit) begin
      pend_d = 1'b1;
    end

    // Writes to addresses at or above DIGITS match no entry and are dropped.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
        shadow_d[i] = bus.wr_data;
      end
    end

    if (!bus.en) begin
      state_d = StOff;
      idx_d   = '0;
      cnt_d   = '0;
      num_d   = NumDark;
    end else begin
      unique case (state_q)
        StOff: begin
          enter_gap = 1'b1;
          gap_idx   = '0;
        end
        StGap: begin
          if (cnt_q == DeadLast) begin
            state_d = StOn;
            cnt_d   = '0;
            if (!blank_q) begin
              dig_n_d = ~(DIGITS'(1) << idx_q);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOn: begin
          if (cnt_q == OnLast) begin
            enter_gap = 1'b1;
            gap_idx   = idx_wrap;
            frame_d   = boundary;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            dig_n_d = dig_n_q;
          end
        end
        default: state_d = StOff;
      endcase
    end

    // GAP entry latches the blank flag and the code for the whole slot. It reads
    // active_d so that digit 0 of a fresh frame already shows committed values.
    if (enter_gap) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (gap_idx == AW'(i)) begin
          gap_blank = bus.blank_mask[i];
          gap_num   = active_d[i];
        end
      end
      state_d = StGap;
      idx_d   = gap_idx;
      cnt_d   = '0;
      blank_d = gap_blank;
      num_d   = gap_blank ? NumDark : gap_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      blank_q  <= 1'b0;
      num_q    <= NumDark;
      dig_n_q  <= '1;
      frame_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      blank_q  <= blank_d;
      num_q    <= num_d;
      dig_n_q  <= dig_n_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.num_o         = num_q;
  assign bus.dig_n_o       = dig_n_q;
  assign bus.frame_o       = frame_q;
  assign bus.commit_pend_o = pend_q;
endmodule
